// File: rtl/neuron_bus_pkg.sv
// neuron_bus_pkg
//   Shared types and defaults for the neuron bus scheduler.
//   - state_e : arbiter state (IDLE, EXT, INT)
//   - owner_e : which side was served most recently (tie-break memory)
//   - *_DEF   : default widths and burst limit
//   - CNT_W   : burst counter width, wide enough for MAX_BURST up to 15
package neuron_bus_pkg;

  localparam int ADDR_W_DEF    = 8;
  localparam int DATA_W_DEF    = 8;
  localparam int MAX_BURST_DEF = 4;
  localparam int CNT_W         = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXT  = 2'd1,
    INT  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_EXT = 1'b0,
    OWN_INT = 1'b1
  } owner_e;

endpackage

// File: rtl/neuron_burst_counter.sv
// neuron_burst_counter
//   Saturating up-counter that tracks how long the current owner has held
//   the bus while the other side is waiting.
//   Ports:
//     clk, reset : clock, synchronous active-high reset
//     clr        : clear to zero (wins over en)
//     en         : count one step, saturating at max
//     max        : saturation value
//     count      : current count
//     at_max     : count has reached max
module neuron_burst_counter
  import neuron_bus_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] max,
  output logic [W-1:0] count,
  output logic         at_max
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != max)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign at_max = (count_q == max);

endmodule

// File: rtl/neuron_bus_scheduler.sv
// neuron_bus_scheduler
//   Arbitrates the neuron memory bus between an external host and the
//   internal engine. Grants are registered (one cycle after the request is
//   sampled); when both sides contend, the owner keeps the bus for at most
//   MAX_BURST cycles before handing over. Address/data/strobe are muxed
//   combinationally from the registered state.
//   Ports:
//     clk, reset                        : clock, synchronous active-high reset
//     ext_* / int_*                     : request, grant, addresses, data,
//                                         write strobe for each source
//     select_external                   : 1 when the external host drives
//     neuron_read/write_address, _data  : muxed bus towards neuron memory
//     neuron_write_enable               : gated write strobe
//     busy                              : any grant active
//
//   state | meaning
//   IDLE  | nobody owns the bus, internal side selected, no writes
//   EXT   | external host owns the bus
//   INT   | internal engine owns the bus
module neuron_bus_scheduler
  import neuron_bus_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ext_req,
  output logic              ext_grant,
  input  logic [ADDR_W-1:0] ext_read_address,
  input  logic [ADDR_W-1:0] ext_write_address,
  input  logic [DATA_W-1:0] ext_write_data,
  input  logic              ext_write_enable,
  input  logic              int_req,
  output logic              int_grant,
  input  logic [ADDR_W-1:0] int_read_address,
  input  logic [ADDR_W-1:0] int_write_address,
  input  logic [DATA_W-1:0] int_write_data,
  input  logic              int_write_enable,
  output logic              select_external,
  output logic [ADDR_W-1:0] neuron_read_address,
  output logic [ADDR_W-1:0] neuron_write_address,
  output logic [DATA_W-1:0] neuron_write_data,
  output logic              neuron_write_enable,
  output logic              busy
);

  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST - 1);

  state_e             state_q, state_d;
  owner_e             last_q, last_d;
  logic [CNT_W-1:0]   burst_cnt;
  logic               burst_at_max;
  logic               burst_clr;
  logic               burst_en;
  logic               burst_done;

  assign burst_done = (burst_cnt == BURST_MAX);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (ext_req && int_req) begin
          state_d = (last_q == OWN_INT) ? EXT : INT;
        end else if (ext_req) begin
          state_d = EXT;
        end else if (int_req) begin
          state_d = INT;
        end
      end
      EXT: begin
        if (!ext_req) begin
          state_d = int_req ? INT : IDLE;
        end else if (int_req && burst_done) begin
          state_d = INT;
        end
      end
      INT: begin
        if (!int_req) begin
          state_d = ext_req ? EXT : IDLE;
        end else if (ext_req && burst_done) begin
          state_d = EXT;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      if (state_d == EXT) last_d = OWN_EXT;
      if (state_d == INT) last_d = OWN_INT;
    end
  end

  // The burst only ages while the other side is actually waiting.
  assign burst_clr = (state_d != state_q);
  assign burst_en  = ((state_q == EXT) && int_req) || ((state_q == INT) && ext_req);

  neuron_burst_counter #(
    .W (CNT_W)
  ) u_burst (
    .clk    (clk),
    .reset  (reset),
    .clr    (burst_clr),
    .en     (burst_en && !burst_at_max),
    .max    (BURST_MAX),
    .count  (burst_cnt),
    .at_max (burst_at_max)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= OWN_INT;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign ext_grant       = (state_q == EXT);
  assign int_grant       = (state_q == INT);
  assign busy            = ext_grant || int_grant;
  assign select_external = ext_grant;

  assign neuron_read_address  = select_external ? ext_read_address  : int_read_address;
  assign neuron_write_address = select_external ? ext_write_address : int_write_address;
  assign neuron_write_data    = select_external ? ext_write_data    : int_write_data;

  // A grant whose request already dropped must not write.
  assign neuron_write_enable = (ext_grant && ext_req && ext_write_enable) ||
                               (int_grant && int_req && int_write_enable);

endmodule

// File: tb/tb_neuron_bus_scheduler.sv
module tb_neuron_bus_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       ext_req, int_req;
  logic [7:0] ext_ra, ext_wa, ext_wd, int_ra, int_wa, int_wd;
  logic       ext_we, int_we;

  logic       ext_grant, int_grant, sel_ext, n_we, busy;
  logic [7:0] n_ra, n_wa, n_wd;

  logic       ext_grant_1, int_grant_1, sel_ext_1, n_we_1, busy_1;
  logic [7:0] n_ra_1, n_wa_1, n_wd_1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  neuron_bus_scheduler #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk                  (clk),
    .reset                (reset),
    .ext_req              (ext_req),
    .ext_grant            (ext_grant),
    .ext_read_address     (ext_ra),
    .ext_write_address    (ext_wa),
    .ext_write_data       (ext_wd),
    .ext_write_enable     (ext_we),
    .int_req              (int_req),
    .int_grant            (int_grant),
    .int_read_address     (int_ra),
    .int_write_address    (int_wa),
    .int_write_data       (int_wd),
    .int_write_enable     (int_we),
    .select_external      (sel_ext),
    .neuron_read_address  (n_ra),
    .neuron_write_address (n_wa),
    .neuron_write_data    (n_wd),
    .neuron_write_enable  (n_we),
    .busy                 (busy)
  );

  neuron_bus_scheduler #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(1)) dut1 (
    .clk                  (clk),
    .reset                (reset),
    .ext_req              (ext_req),
    .ext_grant            (ext_grant_1),
    .ext_read_address     (ext_ra),
    .ext_write_address    (ext_wa),
    .ext_write_data       (ext_wd),
    .ext_write_enable     (ext_we),
    .int_req              (int_req),
    .int_grant            (int_grant_1),
    .int_read_address     (int_ra),
    .int_write_address    (int_wa),
    .int_write_data       (int_wd),
    .int_write_enable     (int_we),
    .select_external      (sel_ext_1),
    .neuron_read_address  (n_ra_1),
    .neuron_write_address (n_wa_1),
    .neuron_write_data    (n_wd_1),
    .neuron_write_enable  (n_we_1),
    .busy                 (busy_1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    ext_req = 1'b0;
    int_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    ext_req = 1'b0; int_req = 1'b0;
    ext_we  = 1'b0; int_we  = 1'b0;
    ext_ra  = 8'hBE; ext_wa = 8'hBE; ext_wd = 8'hBE;
    int_ra  = 8'hEF; int_wa = 8'hEF; int_wd = 8'h5A;

    // reset state
    tick();
    tick();
    chk("rst_ext_grant", ext_grant, 0);
    chk("rst_int_grant", int_grant, 0);
    chk("rst_busy",      busy,      0);
    chk("rst_sel",       sel_ext,   0);
    chk("rst_we",        n_we,      0);
    reset = 1'b0;

    // external alone: granted exactly one edge later
    ext_req = 1'b1;
    ext_we  = 1'b1;
    int_we  = 1'b1;
    #1;
    chk("ext_lat_before", ext_grant, 0);
    tick();
    chk("ext_grant",     ext_grant, 1);
    chk("ext_sel",       sel_ext,   1);
    chk("ext_int_grant", int_grant, 0);
    chk("ext_busy",      busy,      1);
    chk("ext_wa",        n_wa,      8'hBE);
    chk("ext_wd",        n_wd,      8'hBE);
    chk("ext_ra",        n_ra,      8'hBE);
    chk("ext_we",        n_we,      1);
    ext_we = 1'b0;
    #1;
    chk("ext_we_off", n_we, 0);
    // request dropped while still granted: no write
    ext_we  = 1'b1;
    ext_req = 1'b0;
    #1;
    chk("drop_still_granted", ext_grant, 1);
    chk("drop_no_write",      n_we,      0);

    // hand-over to internal on drop
    int_req = 1'b1;
    tick();
    chk("ho_int_grant", int_grant, 1);
    chk("ho_ext_grant", ext_grant, 0);
    chk("ho_sel",       sel_ext,   0);
    chk("ho_ra",        n_ra,      8'hEF);
    chk("ho_wa",        n_wa,      8'hEF);
    chk("ho_wd",        n_wd,      8'h5A);
    chk("ho_int_we",    n_we,      1);
    int_req = 1'b0;
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_we",   n_we, 0);
    // last served is INT, so a tie goes to EXT
    ext_req = 1'b1; int_req = 1'b1;
    tick();
    chk("tie_after_int", ext_grant, 1);
    ext_req = 1'b0; int_req = 1'b0;
    tick();
    // last served is EXT, so a tie goes to INT
    ext_req = 1'b1; int_req = 1'b1;
    tick();
    chk("tie_after_ext", int_grant, 1);

    // contention from reset: EXT x4, INT x4, EXT x4; MAX_BURST=1 alternates
    do_reset();
    ext_req = 1'b1; int_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("burst4_ext_c%0d", i), ext_grant, ((i / 4) % 2 == 0) ? 1 : 0);
      chk($sformatf("burst4_int_c%0d", i), int_grant, ((i / 4) % 2 == 1) ? 1 : 0);
      if (i < 6) begin
        chk($sformatf("burst1_ext_c%0d", i), ext_grant_1, (i % 2 == 0) ? 1 : 0);
        chk($sformatf("burst1_int_c%0d", i), int_grant_1, (i % 2 == 1) ? 1 : 0);
      end
    end

    // burst count holds while the other side is idle
    do_reset();
    ext_req = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("hold_ext", ext_grant, 1);
    int_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hold_tail_c%0d", i), ext_grant, 1);
    end
    tick();
    chk("hold_handover", int_grant, 1);

    // reset during cycle 2 of an INT burst
    do_reset();
    int_req = 1'b1;
    int_we  = 1'b1;
    tick();
    chk("mid_int_c1", int_grant, 1);
    ext_req = 1'b1;
    tick();
    chk("mid_int_c2", int_grant, 1);
    reset = 1'b1;
    tick();
    chk("mid_rst_int_grant", int_grant, 0);
    chk("mid_rst_ext_grant", ext_grant, 0);
    chk("mid_rst_busy",      busy,      0);
    chk("mid_rst_we",        n_we,      0);
    reset = 1'b0;
    tick();
    chk("post_rst_tie", ext_grant, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
